// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: buffers fetched {pc, instr} pairs in a small
// circular FIFO between the fetcher and decode. It raises fetch_stall one
// entry before full, discards all entries on flush, and keeps a sticky
// overflow flag.
module instr_fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [ADDR_W-1:0]          in_pc,
   input  logic [INSTR_W-1:0]         in_instr,
   output logic                       in_ready,
   output logic                       fetch_stall,
   output logic                       out_valid,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [INSTR_W-1:0]         out_instr,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

   // Storage is not reset; occupancy is tracked only by count_q.
   logic [ADDR_W-1:0]  pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_err_q, ovf_err_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Status flags and handshake qualifiers; flush suppresses both push and pop.
   always_comb begin
      full        = (count_q == FULL_LVL);
      empty       = (count_q == '0);
      in_ready    = !full;
      fetch_stall = (count_q >= STALL_LVL);
      out_valid   = !empty;
      push        = in_valid && !full && !flush;
      pop         = !empty && out_ready && !flush;
   end

   // Head of queue, forced to zero when the queue is empty.
   always_comb begin
      out_pc    = '0;
      out_instr = '0;
      if (!empty) begin
         out_pc    = pc_mem[rd_ptr_q];
         out_instr = instr_mem[rd_ptr_q];
      end
   end

   // Next-state logic for the pointers, the occupancy count and the sticky overflow flag.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_err_d = ovf_err_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
         if (in_valid && full) begin
            ovf_err_d = 1'b1;
         end
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   // Entry storage write on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= in_pc;
         instr_mem[wr_ptr_q] <= in_instr;
      end
   end

   assign count   = count_q;
   assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue (DEPTH=4). Inputs change and
// outputs are sampled 1 ns after each rising edge. No output depends
// combinationally on the inputs, so those samples reflect the registered state.
module tb_instr_fetch_queue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        fetch_stall;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        flush;
   logic [2:0]  count;
   logic        ovf_err;

   int total;
   int bad;

   instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .in_ready(in_ready), .fetch_stall(fetch_stall),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_ready(out_ready), .flush(flush), .count(count), .ovf_err(ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
      total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL rst_fetch_stall got=%0b exp=0", fetch_stall); end
      total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf_err got=%0b exp=0", ovf_err); end
      rst = 1'b1;
      repeat (2) step();
      total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL idle_after_rst count=%0d valid=%0b exp 0/0", count, out_valid); end
      $display("reset/idle done count=%0d out_valid=%0b", count, out_valid);
   endtask

   task automatic test_fill();
      logic [31:0] instrs [4];
      instrs[0] = 32'h00000013; instrs[1] = 32'h00100093;
      instrs[2] = 32'h00200113; instrs[3] = 32'h00300193;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_pc    = 32'h30000000 + 32'(4 * i);
         in_instr = instrs[i];
         step();
         total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
         total++; if (fetch_stall !== (i >= 2)) begin bad++; $display("FAIL fill_stall[%0d] got=%0b exp=%0b", i, fetch_stall, (i >= 2)); end
         total++; if (in_ready !== (i < 3)) begin bad++; $display("FAIL fill_in_ready[%0d] got=%0b exp=%0b", i, in_ready, (i < 3)); end
         total++; if (out_pc !== 32'h30000000) begin bad++; $display("FAIL fill_head_pc[%0d] got=%h exp=30000000", i, out_pc); end
         $display("push pc=%h instr=%h count=%0d stall=%0b", in_pc, in_instr, count, fetch_stall);
      end
      in_valid = 1'b0;
      total++; if (out_instr !== 32'h00000013) begin bad++; $display("FAIL fill_head_instr got=%h exp=00000013", out_instr); end
   endtask

   task automatic test_overflow();
      logic [31:0] instrs [4];
      instrs[0] = 32'h00000013; instrs[1] = 32'h00100093;
      instrs[2] = 32'h00200113; instrs[3] = 32'h00300193;
      in_valid = 1'b1; in_pc = 32'h30000010; in_instr = 32'h00400213;
      step();
      in_valid = 1'b0;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
      total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", ovf_err); end
      $display("overflow push pc=30000010 count=%0d ovf_err=%0b", count, ovf_err);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (out_valid !== 1'b1 || out_pc !== 32'h30000000 + 32'(4 * i)) begin bad++; $display("FAIL drain_pc[%0d] got=%h valid=%0b exp=%h", i, out_pc, out_valid, 32'h30000000 + 32'(4 * i)); end
         total++; if (out_instr !== instrs[i]) begin bad++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, out_instr, instrs[i]); end
         $display("pop pc=%h instr=%h", out_pc, out_instr);
         step();
      end
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL drain_empty valid=%0b count=%0d exp 0/0", out_valid, count); end
      total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovf_err); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_pc    = 32'h30000000 + 32'(4 * k);
         in_instr = 32'h00000013 + 32'(k);
         step();
         total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
         total++; if (out_pc !== in_pc || out_instr !== in_instr) begin bad++; $display("FAIL stream_head[%0d] got=%h/%h exp=%h/%h", k, out_pc, out_instr, in_pc, in_instr); end
         $display("stream push pc=%h head=%h count=%0d", in_pc, out_pc, count);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", count); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pc = 32'h30000000 + 32'(4 * i); in_instr = 32'h1000 + 32'(i);
         step();
      end
      total++; if (count !== 3'd3 || fetch_stall !== 1'b1) begin bad++; $display("FAIL flush_pre count=%0d stall=%0b exp 3/1", count, fetch_stall); end
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3000000C; in_instr = 32'h2000; out_ready = 1'b1;
      #1;
      total++; if (out_pc !== 32'h30000000) begin bad++; $display("FAIL flush_cycle_head got=%h exp=30000000", out_pc); end
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear count=%0d valid=%0b exp 0/0", count, out_valid); end
      in_valid = 1'b1; in_pc = 32'h30000100; in_instr = 32'h3000;
      step();
      in_valid = 1'b0;
      total++; if (out_pc !== 32'h30000100 || count !== 3'd1) begin bad++; $display("FAIL flush_next_push pc=%h count=%0d exp 30000100/1", out_pc, count); end
      $display("flush done next head pc=%h count=%0d", out_pc, count);
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_pc = 32'h30000104; in_instr = 32'h3004;
      step();
      in_valid = 1'b0;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL areset_pre count=%0d exp=2", count); end
      #2 rst = 1'b0;
      #1;
      total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL areset_immediate count=%0d valid=%0b exp 0/0", count, out_valid); end
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL areset_ovf got=%0b exp=0", ovf_err); end
      $display("async reset count=%0d out_valid=%0b", count, out_valid);
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_pc = 32'h40000000 + 32'(4 * i); in_instr = 32'h5000 + 32'(i);
         step();
      end
      total++; if (in_ready !== 1'b0 || ovf_err !== 1'b0) begin bad++; $display("FAIL ffull_pre in_ready=%0b ovf=%0b exp 0/0", in_ready, ovf_err); end
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40000010;
      step();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (ovf_err !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL ffull_post ovf=%0b count=%0d exp 0/0", ovf_err, count); end
      $display("flush while full ovf_err=%0b count=%0d", ovf_err, count);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
      out_ready = 1'b0; flush = 1'b0;
      test_reset();
      test_fill();
      test_overflow();
      test_stream();
      test_flush();
      test_async_reset();
      test_flush_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction prefetch queue between the instruction fetcher/instruction memory pair and the decode stage.
- Captures each fetched {pc, instr} pair into a small circular FIFO and presents it to decode with a valid/ready handshake.
- Raises a stall back to the fetcher before it can overflow.
- Discards all buffered entries on a control-flow flush (branch/jump redirect).

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- ADDR_W, 32, PC width; matches the instruction address bus.
- INSTR_W, 32, instruction width; matches the instruction bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  fetch side is presenting a valid pair (fetcher chip-enable is ON).
- in_pc  input  ADDR_W  PC of the presented instruction.
- in_instr  input  INSTR_W  instruction word from instruction memory.
- in_ready  output  1  queue can accept a push this cycle.
- fetch_stall  output  1  fetcher must hold its PC next cycle.
- out_valid  output  1  head entry is valid for decode.
- out_pc  output  ADDR_W  PC of the head entry.
- out_instr  output  INSTR_W  instruction of the head entry.
- out_ready  input  1  decode accepts the head entry this cycle.
- flush  input  1  discard all entries (redirect).
- count  output  $clog2(DEPTH)+1  current occupancy.
- ovf_err  output  1  sticky flag: a push was attempted while the queue was full.

Behaviour:
- State:
  - Storage array of DEPTH {pc, instr} entries.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - ovf_err register.
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ovf_err=0. Storage contents are don't-care.
  - Outputs during reset: out_valid=0, out_pc=0, out_instr=0, in_ready=1, fetch_stall=0.
- Derived flags:
  - full = (count==DEPTH).
  - empty = (count==0).
  - in_ready = !full. No bypass: a pop in the same cycle does not free a slot for a push.
  - fetch_stall = (count >= DEPTH-1). Asserted one entry early, because the fetcher has one instruction in flight after a stall is seen.
- Output path:
  - out_valid = !empty.
  - out_pc and out_instr = storage[rd_ptr] when !empty, otherwise all zeros.
  - Combinational from registered state, so a written entry appears at the output 1 cycle after the push (latency 1).
- Push: in_valid && in_ready → write storage[wr_ptr], wr_ptr+1.
- Pop: out_valid && out_ready → rd_ptr+1.
- Count update: push only +1; pop only −1; push and pop together: unchanged.
- Overflow: in_valid && full → entry dropped, pointers and count unchanged, ovf_err set to 1. ovf_err stays 1 until reset; flush does not clear it.
- Flush (synchronous, highest priority):
  - Next edge: wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in the same cycle is ignored.
  - Does not set ovf_err, even if in_valid && full in that cycle.
  - Outputs in the flush cycle itself still show the pre-flush head.
- Pointer wrap: ptr DEPTH-1 → 0 with no special handling; occupancy is tracked solely by count.
- Reset mid-operation: takes effect immediately (asynchronous); all queued entries are lost.
- Handshake rules:
  - Decode may hold out_ready=1 continuously.
  - Head data is stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then idle: rst=0 for 3 cycles → out_valid=0, count=0, in_ready=1, fetch_stall=0, out_instr=0. Release rst with in_valid=0 → no change.
- Fill: out_ready=0; push pc 0x3000_0000, 0x3000_0004, 0x3000_0008, 0x3000_000C with instrs 0x00000013, 0x00100093, 0x00200113, 0x00300193 → fetch_stall=1 once count=3. After the 4th push: in_ready=0, count=4, out_pc=0x3000_0000, out_instr=0x00000013.
- Overflow: queue full, in_valid=1 with pc 0x3000_0010 → count stays 4, ovf_err=1. Drain with out_ready=1 → outputs appear in order 0x...00, 04, 08, 0C; 0x...10 never appears; ovf_err remains 1.
- Streaming: in_valid=1 and out_ready=1 every cycle, pcs incrementing by 4 from 0x3000_0000 for 10 cycles → count holds at 1 after the first push. Each out_pc equals the previous cycle's in_pc. Pointers wrap past 3 with no loss.
- Flush: count=3 with pcs 0x3000_0000..08; assert flush with in_valid=1, pc=0x3000_000C → next cycle count=0, out_valid=0. 0x3000_000C is not enqueued, and a subsequent push of 0x3000_0100 appears as the next out_pc.
- Async reset mid-stream: drop rst between edges with count=2 → count=0 and out_valid=0 immediately, without waiting for a clock edge.
